button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 143 ++++++++++++++
 tb/tb_button_conditioner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: five-channel push-button front end.
// Each active-low raw button is synchronized, debounced and turned into an
// active-high level plus press/release pulses. The test channel (bit 4) also
// classifies each hold as short or long.
module button_conditioner #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic [4:0] btn_release,
    output logic       test_long,
    output logic       test_short
);

    // Counter widths cover the full parameter value so nothing can wrap.
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW = $clog2(LONG_CYC + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_LONG
    } hold_state_t;

    logic [4:0]    sync_meta;
    logic [4:0]    sync;
    logic [DW-1:0] stab_cnt [5];
    logic [4:0]    toggle;
    logic [4:0]    rise;
    logic [4:0]    fall;
    hold_state_t   state;
    logic [HW-1:0] hold_cnt;

    // Two-flop synchronizer on the inverted (active-high) raw buttons.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of the others.
        if (rst) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= ~btn_raw;
            sync      <= sync_meta;
        end
    end

    // A channel toggles once its synced input has disagreed with the level
    // for DEBOUNCE_CYC consecutive cycles.
    always_comb begin
        // NOTE: default first so no path leaves toggle unassigned (no latch).
        toggle = '0;
        for (int i = 0; i < 5; i++) begin
            toggle[i] = (sync[i] != btn_level[i]) && (stab_cnt[i] == DEB_LAST);
        end
    end

    assign rise = toggle & sync;
    assign fall = toggle & ~sync;

    // Per-channel stability counters, debounced levels and edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counter array is reset too, so a reset mid-debounce
            // throws away any partial count.
            for (int i = 0; i < 5; i++) begin
                stab_cnt[i] <= '0;
            end
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            btn_level   <= btn_level ^ toggle;
            btn_press   <= rise;
            btn_release <= fall;
            for (int i = 0; i < 5; i++) begin
                if ((sync[i] == btn_level[i]) || toggle[i]) begin
                    stab_cnt[i] <= '0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Test-channel hold FSM. It acts on the same edge that produces the
    // press/release pulses, so test_short lines up with btn_release[4] and
    // test_long lands in the LONG_CYC-th debounced-high cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            test_long  <= 1'b0;
            test_short <= 1'b0;
        end else begin
            test_long  <= 1'b0;
            test_short <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise[4]) begin
                        state    <= ST_HOLD;
                        hold_cnt <= HOLD_ONE;
                    end
                end
                ST_HOLD: begin
                    if (fall[4]) begin
                        state      <= ST_IDLE;
                        hold_cnt   <= '0;
                        test_short <= 1'b1;
                    end else if (btn_level[4]) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state     <= ST_LONG;
                            hold_cnt  <= HOLD_MAX;
                            test_long <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                ST_LONG: begin
                    // Counter stays saturated at LONG_CYC until release.
                    if (fall[4]) begin
                        state    <= ST_IDLE;
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed scenarios plus random button
// activity, checked cycle by cycle against a window-based reference model
// through a scoreboard queue.
module tb_button_conditioner;

    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic       clk;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_release;
    logic       test_long;
    logic       test_short;

    button_conditioner #(
        .DEBOUNCE_CYC(DEB),
        .LONG_CYC    (LONG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .test_long  (test_long),
        .test_short (test_short)
    );

    typedef struct packed {
        logic [4:0] level;
        logic [4:0] press;
        logic [4:0] rel;
        logic       lng;
        logic       shrt;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    int long_seen  = 0;
    int short_seen = 0;
    int rel4_seen  = 0;
    int press0_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Sample seen by the debouncer at edge e is the inverted raw input taken
    // two edges earlier (zero right after reset). A channel changes level when
    // the last DEB seen samples all disagree with its current level.
    logic [4:0] hist[$];
    logic [4:0] seen[$];
    logic [4:0] m_level;
    logic [4:0] m_next;
    logic [4:0] m_sample;
    int         run_len;
    int         prev_run;
    bit         all_diff;
    exp_t       m_exp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            seen.delete();
            sb.delete();
            m_level = '0;
            run_len = 0;
        end else begin
            hist.push_back(~btn_raw);
            m_sample = (hist.size() >= 3) ? hist[hist.size() - 3] : 5'b0;
            if (hist.size() > 3) void'(hist.pop_front());
            seen.push_back(m_sample);
            if (seen.size() > DEB) void'(seen.pop_front());
            m_next = m_level;
            if (seen.size() == DEB) begin
                for (int i = 0; i < 5; i++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < DEB; j++) begin
                        if (seen[j][i] == m_level[i]) all_diff = 1'b0;
                    end
                    if (all_diff) m_next[i] = ~m_level[i];
                end
            end
            prev_run = run_len;
            run_len  = m_next[4] ? run_len + 1 : 0;
            m_exp.level = m_next;
            m_exp.press = m_next & ~m_level;
            m_exp.rel   = ~m_next & m_level;
            m_exp.lng   = m_next[4] && (run_len == LONG);
            m_exp.shrt  = m_level[4] && !m_next[4] && (prev_run < LONG);
            sb.push_back(m_exp);
            m_level = m_next;
        end
    end

    // ---------------- monitor ----------------
    exp_t got;
    exp_t want;

    always @(negedge clk) begin
        got = {btn_level, btn_press, btn_release, test_long, test_short};
        if (rst) begin
            check("reset_outputs", 32'(got), 32'd0);
        end else if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 expected=1 entries at %0t", $time);
        end else begin
            want = sb.pop_front();
            check("outputs", 32'(got), 32'(want));
            if (test_long)      long_seen++;
            if (test_short)     short_seen++;
            if (btn_release[4]) rel4_seen++;
            if (btn_press[0])   press0_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [4:0] raw, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            #1;
            btn_raw = raw;
        end
    endtask

    task automatic clear_counts();
        long_seen   = 0;
        short_seen  = 0;
        rel4_seen   = 0;
        press0_seen = 0;
    endtask

    // Counts rising edges until the selected level bit goes high.
    task automatic wait_level(input int bit_idx, input string name, input int expect_cyc);
        int k;
        k = 0;
        while (k < 40 && !btn_level[bit_idx]) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, 32'(k), 32'(expect_cyc));
    endtask

    task automatic do_reset(input logic [4:0] raw_during);
        @(negedge clk);
        #1;
        rst = 1'b1;
        btn_raw = raw_during;
        #1;
        check("async_reset_clear", 32'({btn_level, btn_press, btn_release, test_long, test_short}), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Watchdog keeps the run bounded.
    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [4:0] rnd_raw;

    initial begin
        rst     = 1'b1;
        btn_raw = 5'h1F;
        repeat (3) @(negedge clk);
        #1;
        check("reset_level", 32'(btn_level), 32'd0);
        rst = 1'b0;
        drive(5'h1F, 8);

        // Single stable press on feed: level 6 clocks after the raw change.
        @(negedge clk);
        #1;
        btn_raw = 5'b11011;
        wait_level(2, "feed_latency", 2 + DEB);
        drive(5'b11011, 6);
        drive(5'h1F, 12);

        // Bouncing sleep button never reaches DEB stable cycles.
        clear_counts();
        for (int r = 0; r < 8; r++) begin
            drive(5'b11110, 3);
            drive(5'h1F, 1);
        end
        drive(5'h1F, 10);
        check("bounce_no_press", 32'(press0_seen), 32'd0);

        // Short hold of the test button (10 debounced cycles).
        clear_counts();
        drive(5'b01111, 10);
        drive(5'h1F, 12);
        check("short_hold_short", 32'(short_seen), 32'd1);
        check("short_hold_long", 32'(long_seen), 32'd0);

        // Long hold of the test button (40 debounced cycles).
        clear_counts();
        drive(5'b01111, 40);
        drive(5'h1F, 12);
        check("long_hold_long", 32'(long_seen), 32'd1);
        check("long_hold_short", 32'(short_seen), 32'd0);
        check("long_hold_release", 32'(rel4_seen), 32'd1);

        // Boundary holds just below and exactly at LONG.
        clear_counts();
        drive(5'b01111, LONG - 1);
        drive(5'h1F, 12);
        check("hold_19_short", 32'(short_seen), 32'd1);
        clear_counts();
        drive(5'b01111, LONG);
        drive(5'h1F, 12);
        check("hold_20_long", 32'(long_seen), 32'd1);
        check("hold_20_short", 32'(short_seen), 32'd0);

        // Sleep and play pressed in the same cycle.
        @(negedge clk);
        #1;
        btn_raw = 5'b10110;
        wait_level(0, "dual_latency", 2 + DEB);
        check("dual_press", 32'(btn_press), 32'b01001);
        drive(5'b10110, 5);
        drive(5'h1F, 12);

        // Reset in the middle of a hold; button stays pressed through reset.
        clear_counts();
        drive(5'b01111, 2 + DEB + 15);
        do_reset(5'b01111);
        wait_level(4, "press_after_reset", 2 + DEB);
        check("press4_after_reset", 32'(btn_press[4]), 32'd1);
        check("no_pulse_on_reset", 32'(long_seen + short_seen), 32'd0);
        drive(5'b01111, 4);
        drive(5'h1F, 12);

        // Random activity with occasional bounce and long test holds.
        rnd_raw = 5'h1F;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) rnd_raw[i] = ~rnd_raw[i];
            end
            if ($urandom_range(0, 24) == 0) rnd_raw[4] = ~rnd_raw[4];
            if (c == 700) do_reset(rnd_raw);
            else drive(rnd_raw, 1);
        end

        drive(5'h1F, 20);
        check("final_level", 32'(btn_level), 32'd0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
